// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage in front of a combinational instruction memory.
//   Owns the program counter, captures each returned word together with its PC
//   into a small fetch FIFO, and presents the FIFO head to decode over a
//   valid/ready handshake. A redirect from execute flushes the FIFO and
//   restarts fetching at the (word-aligned) target.
//
// Ports
//   clk            in   clock, all state on rising edge
//   rst_n          in   synchronous active-low reset
//   instr_addr     out  byte address to instruction memory (registered PC)
//   instr_in       in   instruction word returned for instr_addr
//   redirect_valid in   flush FIFO and refetch from redirect_pc
//   redirect_pc    in   redirect target, low two bits ignored
//   out_valid      out  FIFO head holds an instruction
//   out_ready      in   decode accepts the head this cycle
//   out_instr      out  instruction at FIFO head (0 when empty)
//   out_pc         out  PC of instruction at FIFO head (0 when empty)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Entry storage carries no reset: validity is tracked by count_q alone.
  logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];

  logic                  pop;
  logic                  push;
  logic                  can_push;
  logic [ADDR_WIDTH-1:0] redirect_pc_aligned;
  logic [ENTRY_W-1:0]    wr_data;
  logic [ENTRY_W-1:0]    head;

  // Masking (rather than slicing) keeps every redirect_pc bit in use.
  assign redirect_pc_aligned = redirect_pc & ~ADDR_WIDTH'(3);

  assign instr_addr = fetch_pc_q;
  assign out_valid  = (count_q != '0);
  assign head       = fifo_mem[rd_ptr_q];

  // Outputs are forced to zero while empty so the bus is clean after reset
  // even though the storage itself is never cleared.
  assign out_pc    = out_valid ? head[ENTRY_W-1:DATA_WIDTH] : '0;
  assign out_instr = out_valid ? head[DATA_WIDTH-1:0]       : '0;

  always_comb begin
    pop        = out_valid & out_ready & ~redirect_valid;
    // A pop frees a slot on the same edge, so a full FIFO keeps streaming.
    can_push   = (count_q < DEPTH_C) | pop;
    push       = ~redirect_valid & can_push;
    wr_data    = {fetch_pc_q, instr_in};

    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc_aligned;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Scoreboard bench for fetch_unit. The driver applies inputs just after each
//   rising edge and advances a queue-based reference model of the fetch stream;
//   every modelled fetch is pushed onto the expected queue. The monitor runs at
//   each falling edge, compares the DUT outputs with the queue head and pops it
//   when a handshake is about to complete. A second instance with a high reset
//   PC exercises address wraparound from reset.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        rst_n1;
  logic [31:0] instr_addr1;
  logic [31:0] instr_in1;
  logic        out_valid1;
  logic [31:0] out_instr1;
  logic [31:0] out_pc1;

  int total = 0;
  int bad   = 0;

  // Reference model: expected FIFO contents as {pc, instr}, plus next fetch PC.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc = 32'h0;
  logic        m_after_rst = 1'b0;
  logic        u1_done = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign instr_in  = mem_word(instr_addr);
  assign instr_in1 = mem_word(instr_addr1);

  fetch_unit #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr), .instr_in(instr_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  fetch_unit #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n1), .instr_addr(instr_addr1), .instr_in(instr_in1),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid1), .out_ready(1'b1), .out_instr(out_instr1), .out_pc(out_pc1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, then advance the model.
  task automatic cycle(input logic rn, input logic rdy, input logic rv, input logic [31:0] rpc);
    rst_n          = rn;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
    m_after_rst = !rn;
    if (!rn) begin
      exp_q.delete();
      m_pc = 32'h0;
    end else if (rv) begin
      exp_q.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else if (exp_q.size() < DEPTH) begin
      // the monitor has already removed an entry popped on this edge
      exp_q.push_back({m_pc, mem_word(m_pc)});
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    logic        exp_v;
    logic [63:0] hd;
    exp_v = (exp_q.size() != 0);
    chk("out_valid", {63'b0, out_valid}, {63'b0, exp_v});
    chk("instr_addr", {32'b0, instr_addr}, {32'b0, m_pc});
    if (exp_v) begin
      hd = exp_q[0];
      chk("out_pc", {32'b0, out_pc}, {32'b0, hd[63:32]});
      chk("out_instr", {32'b0, out_instr}, {32'b0, hd[31:0]});
      if (rst_n && out_ready && !redirect_valid) void'(exp_q.pop_front());
    end else if (m_after_rst) begin
      chk("rst_out_pc", {32'b0, out_pc}, 64'h0);
      chk("rst_out_instr", {32'b0, out_instr}, 64'h0);
    end
  end

  // Wraparound from a high reset PC on the second instance.
  initial begin
    logic [31:0] wexp [4];
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000; wexp[3] = 32'h0000_0004;
    rst_n1 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n1 = 1'b1;
    @(negedge clk);
    chk("wrap_rst_valid", {63'b0, out_valid1}, 64'h0);
    chk("wrap_rst_addr", {32'b0, instr_addr1}, {32'b0, 32'hFFFF_FFF8});
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_valid", {63'b0, out_valid1}, 64'h1);
      chk("wrap_pc", {32'b0, out_pc1}, {32'b0, wexp[i]});
      chk("wrap_instr", {32'b0, out_instr1}, {32'b0, mem_word(wexp[i])});
    end
    u1_done = 1'b1;
  end

  initial begin
    // 1: reset then free-running stream
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);
    // 2: reset, decode stalled for 5 cycles, then released
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    // 3: redirect while streaming
    cycle(1, 1, 1, 32'h0000_0040);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
    // 4: unaligned redirect with full FIFO and ready high
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 32'h0000_0043);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
    // 5: one-edge reset mid-stream
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
    // PC wrap via redirect near the top of the address space
    cycle(1, 1, 1, 32'hFFFF_FFF5);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        rn, rdy, rv;
      logic [31:0] rpc;
      rn  = ($urandom_range(0, 99) >= 2);
      rv  = ($urandom_range(0, 99) < 10);
      rdy = ($urandom_range(0, 99) < 70);
      rpc = $urandom;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      cycle(rn, rdy, rv, rpc);
    end
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
    if (!u1_done) begin
      bad++;
      total++;
      $display("FAIL wrap_done: actual=0 required=1");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
